// File: rtl/bw_r_irf_pkg.sv
// Shared types for the IRF window-swap slice:
// op codes and window FSM states.
package bw_r_irf_pkg;

  typedef enum logic [1:0] {
    IRF_OP_NOP     = 2'b00,
    IRF_OP_SAVE    = 2'b01,
    IRF_OP_RESTORE = 2'b10,
    IRF_OP_SWAP    = 2'b11
  } irf_op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SAVE,
    ST_RD,
    ST_LOAD,
    ST_NOPD
  } irf_st_e;

endpackage

// File: rtl/bw_r_irf_win_ram.sv
// Saved-window storage: one write port, one
// synchronous read port, no reset (block RAM).
module bw_r_irf_win_ram #(
  parameter int DW    = 72,
  parameter int DEPTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  // write port
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // registered read port, holds last value when idle
  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/bw_r_irf_win_swap.sv
// One architectural register slice: NTHR working
// registers backed by NWIN saved windows each.
module bw_r_irf_win_swap
  import bw_r_irf_pkg::*;
#(
  parameter int NTHR = 4,
  parameter int DW   = 72,
  parameter int NWIN = 8,
  localparam int TW  = $clog2(NTHR),
  localparam int WW  = $clog2(NWIN)
) (
  input  logic               clk,
  input  logic               rst_l,
  input  logic [NTHR-1:0]    wr_en,
  input  logic [NTHR*DW-1:0] wr_data,
  input  logic [TW-1:0]      rd_thread,
  output logic [DW-1:0]      rd_data,
  input  logic               op_vld,
  output logic               op_rdy,
  input  logic [1:0]         op_code,
  input  logic [TW-1:0]      op_thr,
  input  logic [WW-1:0]      op_save_win,
  input  logic [WW-1:0]      op_rst_win,
  output logic               op_done,
  output logic               rst_miss,
  output logic               wr_conflict
);

  localparam int DEPTH = NTHR * NWIN;
  localparam int AW    = TW + WW;

  irf_st_e       state;
  logic [TW-1:0] thr_q;
  logic [WW-1:0] save_q;
  logic [WW-1:0] rst_q;
  logic          swap_q;

  logic [DW-1:0]    regs [NTHR];
  logic [DEPTH-1:0] valid;

  logic          ram_we;
  logic          ram_re;
  logic [AW-1:0] ram_waddr;
  logic [AW-1:0] ram_raddr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_q;
  logic          load;
  logic          thr_wr;
  logic [DW-1:0] thr_wdata;

  assign op_rdy    = (state == ST_IDLE);
  assign load      = (state == ST_LOAD);
  assign thr_wr    = wr_en[thr_q];
  assign thr_wdata = wr_data[thr_q*DW +: DW];

  assign ram_we    = (state == ST_SAVE);
  assign ram_re    = (state == ST_RD);
  assign ram_waddr = {thr_q, save_q};
  assign ram_raddr = {thr_q, rst_q};
  assign ram_wdata = thr_wr ? thr_wdata
                            : regs[thr_q];

  assign wr_conflict = load & thr_wr;
  assign rd_data     = regs[rd_thread];

  // window FSM with registered done/miss pulses
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state    <= ST_IDLE;
      thr_q    <= '0;
      save_q   <= '0;
      rst_q    <= '0;
      swap_q   <= 1'b0;
      op_done  <= 1'b0;
      rst_miss <= 1'b0;
    end else begin
      op_done  <= 1'b0;
      rst_miss <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (op_vld) begin
            thr_q  <= op_thr;
            save_q <= op_save_win;
            rst_q  <= op_rst_win;
            swap_q <= (op_code == IRF_OP_SWAP);
            unique case (1'b1)
              op_code == IRF_OP_NOP: begin
                state   <= ST_NOPD;
                op_done <= 1'b1;
              end
              op_code == IRF_OP_SAVE: begin
                state   <= ST_SAVE;
                op_done <= 1'b1;
              end
              op_code == IRF_OP_RESTORE: begin
                state <= ST_RD;
              end
              op_code == IRF_OP_SWAP: begin
                state <= ST_SAVE;
              end
            endcase
          end
        end
        ST_SAVE: begin
          state <= swap_q ? ST_RD : ST_IDLE;
        end
        ST_RD: begin
          state    <= ST_LOAD;
          op_done  <= 1'b1;
          rst_miss <= ~valid[{thr_q, rst_q}];
        end
        ST_LOAD: state <= ST_IDLE;
        ST_NOPD: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // per-window valid bits, set by the save phase
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      valid <= '0;
    end else if (ram_we) begin
      valid[ram_waddr] <= 1'b1;
    end
  end

  // working registers; a restore load wins
  // over a same-cycle write to that thread
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      for (int t = 0; t < NTHR; t++)
        regs[t] <= '0;
    end else begin
      for (int t = 0; t < NTHR; t++) begin
        if (load && thr_q == TW'(t))
          regs[t] <= rst_miss ? '0 : ram_q;
        else if (wr_en[t])
          regs[t] <= wr_data[t*DW +: DW];
      end
    end
  end

  bw_r_irf_win_ram #(
    .DW    (DW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .re    (ram_re),
    .raddr (ram_raddr),
    .rdata (ram_q)
  );

endmodule

// File: tb/tb_bw_r_irf_win_swap.sv
// Directed bench for bw_r_irf_win_swap:
// save / restore / swap, conflicts, reset abort.
module tb_bw_r_irf_win_swap;

  localparam int NTHR = 4;
  localparam int DW   = 72;
  localparam int NWIN = 8;
  localparam int TW   = 2;
  localparam int WW   = 3;

  localparam logic [1:0] NOP = 2'b00;
  localparam logic [1:0] SAV = 2'b01;
  localparam logic [1:0] RES = 2'b10;
  localparam logic [1:0] SWP = 2'b11;

  logic               clk = 1'b0;
  logic               rst_l = 1'b0;
  logic [NTHR-1:0]    wr_en = '0;
  logic [NTHR*DW-1:0] wr_data = '0;
  logic [TW-1:0]      rd_thread = '0;
  logic [DW-1:0]      rd_data;
  logic               op_vld = 1'b0;
  logic               op_rdy;
  logic [1:0]         op_code = '0;
  logic [TW-1:0]      op_thr = '0;
  logic [WW-1:0]      op_save_win = '0;
  logic [WW-1:0]      op_rst_win = '0;
  logic               op_done;
  logic               rst_miss;
  logic               wr_conflict;

  int n_chk = 0;
  int n_pass = 0;

  bw_r_irf_win_swap #(
    .NTHR (NTHR),
    .DW   (DW),
    .NWIN (NWIN)
  ) dut (
    .clk         (clk),
    .rst_l       (rst_l),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .rd_thread   (rd_thread),
    .rd_data     (rd_data),
    .op_vld      (op_vld),
    .op_rdy      (op_rdy),
    .op_code     (op_code),
    .op_thr      (op_thr),
    .op_save_win (op_save_win),
    .op_rst_win  (op_rst_win),
    .op_done     (op_done),
    .rst_miss    (rst_miss),
    .wr_conflict (wr_conflict)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [DW-1:0] obs,
                     input logic [DW-1:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %h want %h",
                tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int t,
                    input logic [DW-1:0] d);
    wr_en[t] = 1'b1;
    wr_data[t*DW +: DW] = d;
    tick();
    wr_en[t] = 1'b0;
  endtask

  task automatic rd_chk(input string tag,
                        input int t,
                        input logic [DW-1:0] exp);
    rd_thread = TW'(t);
    #1;
    chk(tag, rd_data, exp);
  endtask

  task automatic start_op(input logic [1:0] c,
                          input int t,
                          input int sw,
                          input int rw);
    op_vld      = 1'b1;
    op_code     = c;
    op_thr      = TW'(t);
    op_save_win = WW'(sw);
    op_rst_win  = WW'(rw);
    chk("op_rdy_idle", {71'd0, op_rdy}, 72'd1);
    tick();
    op_vld = 1'b0;
  endtask

  task automatic wait_done(output int cyc,
                           output logic miss,
                           output logic conf);
    cyc  = 0;
    miss = 1'b0;
    conf = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (op_done === 1'b1) begin
        cyc  = c;
        miss = rst_miss;
        conf = wr_conflict;
        break;
      end
      tick();
    end
  endtask

  task automatic run_op(input string tag,
                        input logic [1:0] c,
                        input int t,
                        input int sw,
                        input int rw,
                        input int exp_cyc,
                        input logic exp_miss);
    int   cyc;
    logic miss;
    logic conf;
    start_op(c, t, sw, rw);
    wait_done(cyc, miss, conf);
    chk({tag, "_lat"}, DW'(cyc), DW'(exp_cyc));
    chk({tag, "_miss"}, {71'd0, miss},
        {71'd0, exp_miss});
    chk({tag, "_conf"}, {71'd0, conf}, 72'd0);
    tick();
  endtask

  initial begin
    int   cyc;
    logic miss;
    logic conf;

    // reset state
    #12;
    chk("rst_rdy", {71'd0, op_rdy}, 72'd1);
    chk("rst_done", {71'd0, op_done}, 72'd0);
    chk("rst_miss", {71'd0, rst_miss}, 72'd0);
    chk("rst_conf", {71'd0, wr_conflict}, 72'd0);
    rd_chk("rst_reg0", 0, 72'd0);
    rd_chk("rst_reg3", 3, 72'd0);
    tick();
    rst_l = 1'b1;
    tick();

    // restore of never-saved window
    run_op("res_miss", RES, 1, 0, 3, 2, 1'b1);
    rd_chk("res_miss_reg1", 1, 72'd0);

    // nop
    run_op("nop", NOP, 0, 0, 0, 1, 1'b0);

    // save then restore after overwrite
    wr(2, 72'hA5);
    run_op("sav2", SAV, 2, 5, 0, 1, 1'b0);
    wr(2, 72'h3C);
    rd_chk("wr2_3c", 2, 72'h3C);
    run_op("res2", RES, 2, 0, 5, 2, 1'b0);
    rd_chk("res2_reg", 2, 72'hA5);

    // swap thread 0
    wr(0, 72'h22);
    run_op("sav0", SAV, 0, 2, 0, 1, 1'b0);
    wr(0, 72'h11);
    run_op("swp0", SWP, 0, 4, 2, 3, 1'b0);
    rd_chk("swp0_reg", 0, 72'h22);
    run_op("res0", RES, 0, 0, 4, 2, 1'b0);
    rd_chk("res0_reg", 0, 72'h11);

    // swap with identical windows
    wr(1, 72'h5A);
    run_op("swp_same", SWP, 1, 7, 7, 3, 1'b0);
    rd_chk("swp_same_reg", 1, 72'h5A);

    // save bypasses a write in the save cycle
    start_op(SAV, 3, 0, 0);
    wr_en[3] = 1'b1;
    wr_data[3*DW +: DW] = 72'h77;
    wait_done(cyc, miss, conf);
    chk("savbyp_lat", DW'(cyc), 72'd1);
    tick();
    wr_en = '0;
    rd_chk("savbyp_reg", 3, 72'h77);
    wr(3, 72'h55);
    rd_chk("wr3_55", 3, 72'h55);
    run_op("res3", RES, 3, 0, 0, 2, 1'b0);
    rd_chk("res3_reg", 3, 72'h77);

    // load overrides a same-cycle write
    wr(1, 72'h99);
    run_op("sav1", SAV, 1, 6, 0, 1, 1'b0);
    wr(1, 72'h44);
    start_op(RES, 1, 0, 6);
    tick();
    wr_en = 4'b0011;
    wr_data[1*DW +: DW] = 72'hEE;
    wr_data[0 +: DW] = 72'h33;
    @(negedge clk);
    chk("cf_done", {71'd0, op_done}, 72'd1);
    chk("cf_conf", {71'd0, wr_conflict}, 72'd1);
    chk("cf_miss", {71'd0, rst_miss}, 72'd0);
    tick();
    wr_en = '0;
    rd_chk("cf_reg1", 1, 72'h99);
    rd_chk("cf_reg0", 0, 72'h33);

    // reset during the read phase of a swap
    start_op(SWP, 2, 1, 5);
    tick();
    rst_l = 1'b0;
    #1;
    chk("ra_rdy", {71'd0, op_rdy}, 72'd1);
    chk("ra_done", {71'd0, op_done}, 72'd0);
    rd_chk("ra_reg0", 0, 72'd0);
    rd_chk("ra_reg1", 1, 72'd0);
    rd_chk("ra_reg2", 2, 72'd0);
    rd_chk("ra_reg3", 3, 72'd0);
    tick();
    rst_l = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("ra_nodone", {71'd0, op_done}, 72'd0);
      tick();
    end
    run_op("ra_res2", RES, 2, 0, 5, 2, 1'b1);
    run_op("ra_res0", RES, 0, 0, 4, 2, 1'b1);
    rd_chk("ra_res0_reg", 0, 72'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
